// File: rtl/nios_mult_pipe.sv
// nios_mult_pipe: pipelined limb-split integer multiplier returning MUL low word or MULX* high word
module nios_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter bit OUT_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy
);
  localparam int H  = DATA_W / 2;
  localparam int W2 = 2 * DATA_W;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh, m_ca, m_cb, ca, cb, lo, hi, a_res, o_res;
  logic [1:0]        m_op;
  logic              m_valid, a_valid, o_valid;
  logic [W2-1:0]     p;
  assign ca = (op[1] && src1[DATA_W-1]) ? src2 : '0;
  assign cb = (op == 2'b11 && src2[DATA_W-1]) ? src1 : '0;
  assign p  = W2'(pp_ll) + (W2'(pp_lh) << H) + (W2'(pp_hl) << H) + (W2'(pp_hh) << DATA_W);
  assign lo = p[DATA_W-1:0];
  assign hi = p[W2-1:DATA_W] - m_ca - m_cb;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_ll   <= '0;
      pp_lh   <= '0;
      pp_hl   <= '0;
      pp_hh   <= '0;
      m_ca    <= '0;
      m_cb    <= '0;
      m_op    <= '0;
      m_valid <= 1'b0;
      a_res   <= '0;
      a_valid <= 1'b0;
      o_res   <= '0;
      o_valid <= 1'b0;
    end else if (en) begin
      pp_ll   <= DATA_W'(src1[H-1:0])      * DATA_W'(src2[H-1:0]);
      pp_lh   <= DATA_W'(src1[H-1:0])      * DATA_W'(src2[DATA_W-1:H]);
      pp_hl   <= DATA_W'(src1[DATA_W-1:H]) * DATA_W'(src2[H-1:0]);
      pp_hh   <= DATA_W'(src1[DATA_W-1:H]) * DATA_W'(src2[DATA_W-1:H]);
      m_ca    <= ca;
      m_cb    <= cb;
      m_op    <= op;
      m_valid <= in_valid;
      a_res   <= (m_op == 2'b00) ? lo : hi;
      a_valid <= m_valid;
      o_res   <= a_res;
      o_valid <= a_valid;
    end
  end
  assign out_valid = OUT_REG ? o_valid : a_valid;
  assign result    = OUT_REG ? o_res : a_res;
  assign busy      = m_valid | a_valid | (OUT_REG & o_valid);
endmodule

// File: tb/tb_nios_mult_pipe.sv
// tb_nios_mult_pipe: scoreboard bench for a 32-bit/2-stage and a 16-bit/3-stage multiplier instance
module tb_nios_mult_pipe;
  typedef struct {
    int          ch;
    logic [31:0] exp;
    int          acc;
  } ent_t;
  logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0;
  logic [1:0]  iv = '0, op = '0;
  logic [31:0] src1 = '0, src2 = '0, r0;
  logic [15:0] r1;
  logic        ov0, ov1, b0, b1;
  int          errs = 0, total = 0, ecnt = 0;
  ent_t        q[$];
  bit          prev_en = 1'b0, prev_rst = 1'b0;
  bit          pov[2];
  logic [31:0] pres[2];
  always #5 clk = ~clk;
  nios_mult_pipe #(.DATA_W(32), .OUT_REG(0)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(iv[0]), .op(op),
    .src1(src1), .src2(src2), .out_valid(ov0), .result(r0), .busy(b0));
  nios_mult_pipe #(.DATA_W(16), .OUT_REG(1)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(iv[1]), .op(op),
    .src1(src1[15:0]), .src2(src2[15:0]), .out_valid(ov1), .result(r1), .busy(b1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] m, ea, eb, pr;
    m  = (64'd1 << w) - 64'd1;
    ea = {32'b0, a} & m;
    eb = {32'b0, b} & m;
    if (o[1] && ea[w-1]) ea = ea | ~m;
    if (o == 2'b11 && eb[w-1]) eb = eb | ~m;
    pr = ea * eb;
    return (o == 2'b00) ? pr[31:0] & m[31:0] : 32'((pr >> w) & m);
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_8000;
      default: return $urandom;
    endcase
  endfunction
  task automatic cyc(input bit e, input bit v0, input bit v1, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b, input bit use_k, input logic [31:0] k);
    en = e; iv = {v1, v0}; op = o; src1 = a; src2 = b;
    if (e && v0 && reset_n) q.push_back('{0, use_k ? k : model(o, a, b, 32), ecnt});
    if (e && v1 && reset_n) q.push_back('{1, use_k ? k : model(o, a, b, 16), ecnt});
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00, $urandom, $urandom, 1'b0, 32'h0);
  endtask
  always @(posedge clk) if (reset_n && en) ecnt <= ecnt + 1;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      bit          ovc, bc;
      logic [31:0] rc;
      int          infl, idx;
      ovc = (c == 0) ? ov0 : ov1;
      bc  = (c == 0) ? b0 : b1;
      rc  = (c == 0) ? r0 : {16'b0, r1};
      if (reset_n && prev_rst) begin
        infl = 0;
        idx  = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].ch == c && q[i].acc < ecnt) begin
            infl++;
            if (idx < 0) idx = i;
          end
        end
        chk($sformatf("busy ch%0d", c), 32'(bc), 32'(infl != 0));
        if (!prev_en) begin
          chk($sformatf("stall out_valid ch%0d", c), 32'(ovc), 32'(pov[c]));
          chk($sformatf("stall result ch%0d", c), rc, pres[c]);
        end
        if (ovc && en) begin
          if (idx < 0) chk($sformatf("spurious out_valid ch%0d", c), 32'(ovc), 32'd0);
          else begin
            chk($sformatf("result ch%0d", c), rc, q[idx].exp);
            chk($sformatf("latency ch%0d", c), 32'(ecnt - q[idx].acc), 32'(c == 0 ? 2 : 3));
            q.delete(idx);
          end
        end
      end
      pov[c]  = ovc;
      pres[c] = rc;
    end
    prev_en  = en;
    prev_rst = reset_n;
  end
  initial begin
    @(posedge clk);
    #1;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'h1234_5678, 32'h9abc_def0, 1'b0, 32'h0);
    chk("reset out_valid", {30'b0, ov1, ov0}, 32'h0);
    chk("reset result32", r0, 32'h0);
    chk("reset result16", {16'b0, r1}, 32'h0);
    chk("reset busy", {30'b0, b1, b0}, 32'h0);
    reset_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 32'h0001_2345, 32'h0001_0000, 1'b1, 32'h2345_0000);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0001);
    idle(4);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, $urandom, $urandom, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, $urandom, $urandom, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 2'b01, $urandom, $urandom, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, $urandom, $urandom, 1'b0, 32'h0);
    idle(5);
    for (int i = 0; i < 8; i++) cyc(1'b1, i % 2 == 0, 1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 32'h0);
    idle(4);
    cyc(1'b1, 1'b1, 1'b1, 2'b01, $urandom, $urandom, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 2'b11, $urandom, $urandom, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("midflight reset out_valid", {30'b0, ov1, ov0}, 32'h0);
    chk("midflight reset busy", {30'b0, b1, b0}, 32'h0);
    chk("midflight reset result", r0, 32'h0);
    q.delete();
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'h5, 32'h7, 1'b0, 32'h0);
    reset_n = 1'b1;
    idle(5);
    cyc(1'b1, 1'b0, 1'b1, 2'b11, 32'h8000, 32'h8000, 1'b1, 32'h4000);
    cyc(1'b1, 1'b0, 1'b1, 2'b00, 32'hFFFF, 32'h0003, 1'b1, 32'hFFFD);
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 9) != 0, 2'($urandom), pick(), pick(), 1'b0, 32'h0);
    for (int i = 0; i < 30 && q.size() != 0; i++) idle(1);
    chk("drain", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
